// File: rtl/dma_rd_cmd_scheduler_if.sv
// Handshake and command bus between descriptor front-end, read-command scheduler and DMA read block.
// The master modport is the scheduler; the slave modport is the surrounding environment.
interface dma_rd_cmd_scheduler_if #(
    parameter int ID_W = 8
);
    logic            desc_valid_i;
    logic            desc_ready_o;
    logic [31:0]     desc_src_addr_i;
    logic [31:0]     desc_len_i;
    logic [ID_W-1:0] desc_id_i;
    logic            dma_rd_fifo_command_req_o;
    logic [31:0]     dma_rd_addr_o;
    logic [15:0]     dma_rd_bytes_to_transfer_o;
    logic            dma_rd_fifo_full_i;
    logic            dma_rd_data_valid_i;
    logic            desc_done_o;
    logic [ID_W-1:0] desc_done_id_o;
    logic            busy_o;
    logic            err_o;

    modport master (
        input  desc_valid_i, desc_src_addr_i, desc_len_i, desc_id_i,
        input  dma_rd_fifo_full_i, dma_rd_data_valid_i,
        output desc_ready_o, dma_rd_fifo_command_req_o, dma_rd_addr_o,
        output dma_rd_bytes_to_transfer_o, desc_done_o, desc_done_id_o, busy_o, err_o
    );

    modport slave (
        output desc_valid_i, desc_src_addr_i, desc_len_i, desc_id_i,
        output dma_rd_fifo_full_i, dma_rd_data_valid_i,
        input  desc_ready_o, dma_rd_fifo_command_req_o, dma_rd_addr_o,
        input  dma_rd_bytes_to_transfer_o, desc_done_o, desc_done_id_o, busy_o, err_o
    );
endinterface

// File: rtl/dma_rd_cmd_scheduler.sv
// Splits one read descriptor into boundary-safe burst commands and tracks returned 256-bit beats
// until the whole descriptor has come back.
module dma_rd_cmd_scheduler #(
    parameter int MAX_CHUNK = 2048,
    parameter int ID_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    dma_rd_cmd_scheduler_if.master bus
);
    localparam logic [31:0] CHUNK_SIZE = 32'(MAX_CHUNK);
    localparam logic [31:0] CHUNK_MASK = 32'(MAX_CHUNK - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_ISSUE,
        S_WAIT_DATA,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [31:0]     r_addr;
    logic [31:0]     r_rem;
    logic [ID_W-1:0] r_id;
    logic [31:0]     r_out_addr;
    logic [15:0]     r_out_bytes;
    logic [27:0]     r_outstanding;
    logic            r_err;

    logic [31:0]     w_to_bound;
    logic [15:0]     w_chunk;
    logic [27:0]     w_beats;
    logic            w_issue_fire;
    logic            w_underflow;
    logic [27:0]     w_outstanding_next;

    // Distance to the next MAX_CHUNK boundary is always 1..MAX_CHUNK, so it fits 16 bits.
    assign w_to_bound = CHUNK_SIZE - (r_addr & CHUNK_MASK);
    assign w_chunk    = (r_rem < w_to_bound) ? r_rem[15:0] : w_to_bound[15:0];

    assign w_beats      = {17'd0, r_out_bytes[15:5]} + {27'd0, |r_out_bytes[4:0]};
    assign w_issue_fire = (r_state == S_ISSUE) && !bus.dma_rd_fifo_full_i;

    // A beat with nothing outstanding (and nothing being issued) is an error; the counter holds at 0.
    assign w_underflow = bus.dma_rd_data_valid_i && (r_outstanding == 28'd0) && !w_issue_fire;
    assign w_outstanding_next = w_underflow ? 28'd0 :
        r_outstanding + (w_issue_fire ? w_beats : 28'd0) - {27'd0, bus.dma_rd_data_valid_i};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next                  = r_state;
        bus.desc_ready_o              = 1'b0;
        bus.dma_rd_fifo_command_req_o = 1'b0;
        bus.desc_done_o               = 1'b0;
        bus.desc_done_id_o            = '0;
        bus.busy_o                    = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                bus.desc_ready_o = 1'b1;
                if (bus.desc_valid_i) begin
                    w_state_next = (bus.desc_len_i == 32'd0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                w_state_next = S_ISSUE;
            end
            S_ISSUE: begin
                bus.dma_rd_fifo_command_req_o = !bus.dma_rd_fifo_full_i;
                if (!bus.dma_rd_fifo_full_i) begin
                    w_state_next = (r_rem == {16'd0, r_out_bytes}) ? S_WAIT_DATA : S_CALC;
                end
            end
            S_WAIT_DATA: begin
                if (w_outstanding_next == 28'd0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                bus.desc_done_o    = 1'b1;
                bus.desc_done_id_o = r_id;
                w_state_next       = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr        <= '0;
            r_rem         <= '0;
            r_id          <= '0;
            r_out_addr    <= '0;
            r_out_bytes   <= '0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            r_outstanding <= w_outstanding_next;
            if (w_underflow) begin
                r_err <= 1'b1;
            end
            if (r_state == S_IDLE && bus.desc_valid_i) begin
                r_addr <= bus.desc_src_addr_i;
                r_rem  <= bus.desc_len_i;
                r_id   <= bus.desc_id_i;
            end
            if (r_state == S_CALC) begin
                r_out_addr  <= r_addr;
                r_out_bytes <= w_chunk;
            end
            if (w_issue_fire) begin
                r_addr <= r_addr + {16'd0, r_out_bytes};
                r_rem  <= r_rem - {16'd0, r_out_bytes};
            end
        end
    end

    assign bus.dma_rd_addr_o              = r_out_addr;
    assign bus.dma_rd_bytes_to_transfer_o = r_out_bytes;
    assign bus.err_o                      = r_err;

endmodule

// File: tb/tb_dma_rd_cmd_scheduler.sv
// Directed bench for dma_rd_cmd_scheduler: command splitting, back-pressure, beat counting,
// underflow error and asynchronous reset mid-operation.
module tb_dma_rd_cmd_scheduler;
    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;
    int   strobe_cnt;
    int   done_cnt;
    int   s0;
    int   d0;

    dma_rd_cmd_scheduler_if #(.ID_W(8)) bus ();

    dma_rd_cmd_scheduler #(.MAX_CHUNK(2048), .ID_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.dma_rd_fifo_command_req_o === 1'b1) strobe_cnt++;
        if (bus.desc_done_o === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_desc(input logic [31:0] addr, input logic [31:0] len, input logic [7:0] id);
        chk("ready_before_accept", {31'd0, bus.desc_ready_o}, 32'd1);
        bus.desc_valid_i    = 1'b1;
        bus.desc_src_addr_i = addr;
        bus.desc_len_i      = len;
        bus.desc_id_i       = id;
        tick();
        bus.desc_valid_i    = 1'b0;
    endtask

    task automatic chk_cmd(input string tag, input logic [31:0] addr, input logic [15:0] bytes);
        chk({tag, "_req"}, {31'd0, bus.dma_rd_fifo_command_req_o}, 32'd1);
        chk({tag, "_addr"}, bus.dma_rd_addr_o, addr);
        chk({tag, "_bytes"}, {16'd0, bus.dma_rd_bytes_to_transfer_o}, {16'd0, bytes});
        $display("cmd %s addr=0x%08h bytes=%0d", tag, bus.dma_rd_addr_o, bus.dma_rd_bytes_to_transfer_o);
    endtask

    // Drives n beats; the last one lands on the edge that should complete the descriptor.
    task automatic beats(input int n);
        for (int i = 0; i < n; i++) begin
            bus.dma_rd_data_valid_i = 1'b1;
            tick();
        end
        bus.dma_rd_data_valid_i = 1'b0;
    endtask

    task automatic chk_done(input string tag, input logic [7:0] id);
        chk({tag, "_done"}, {31'd0, bus.desc_done_o}, 32'd1);
        chk({tag, "_done_id"}, {24'd0, bus.desc_done_id_o}, {24'd0, id});
        $display("done %s id=0x%02h", tag, bus.desc_done_id_o);
        tick();
        chk({tag, "_done_pulse_end"}, {31'd0, bus.desc_done_o}, 32'd0);
        chk({tag, "_idle_ready"}, {31'd0, bus.desc_ready_o}, 32'd1);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; strobe_cnt = 0; done_cnt = 0;
        reset_n = 1'b0;
        bus.desc_valid_i = 1'b0; bus.desc_src_addr_i = '0; bus.desc_len_i = '0; bus.desc_id_i = '0;
        bus.dma_rd_fifo_full_i = 1'b0; bus.dma_rd_data_valid_i = 1'b0;
        tick(); tick();
        chk("rst_ready", {31'd0, bus.desc_ready_o}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("rst_req", {31'd0, bus.dma_rd_fifo_command_req_o}, 32'd0);
        chk("rst_done", {31'd0, bus.desc_done_o}, 32'd0);
        chk("rst_err", {31'd0, bus.err_o}, 32'd0);
        chk("rst_addr", bus.dma_rd_addr_o, 32'd0);
        chk("rst_bytes", {16'd0, bus.dma_rd_bytes_to_transfer_o}, 32'd0);
        @(negedge clk) reset_n = 1'b1;
        tick();

        // 1: 0x1000 / 5000 bytes -> 2048, 2048, 904; 64+64+29 = 157 beats
        send_desc(32'h1000, 32'd5000, 8'h11);
        chk("t1_calc_busy", {31'd0, bus.busy_o}, 32'd1);
        chk("t1_calc_noreq", {31'd0, bus.dma_rd_fifo_command_req_o}, 32'd0);
        tick(); chk_cmd("t1_c0", 32'h1000, 16'd2048);
        tick(); chk("t1_gap_noreq", {31'd0, bus.dma_rd_fifo_command_req_o}, 32'd0);
        tick(); chk_cmd("t1_c1", 32'h1800, 16'd2048);
        tick(); tick(); chk_cmd("t1_c2", 32'h2000, 16'd904);
        tick();
        d0 = done_cnt;
        beats(156);
        chk("t1_no_done_156", {31'd0, bus.desc_done_o}, 32'd0);
        chk("t1_no_done_cnt", done_cnt, d0);
        chk("t1_busy_wait", {31'd0, bus.busy_o}, 32'd1);
        beats(1);
        chk_done("t1", 8'h11);
        chk("t1_no_err", {31'd0, bus.err_o}, 32'd0);

        // 2: 0x1F00 / 512 bytes -> two 256-byte commands split at 0x2000
        send_desc(32'h1F00, 32'd512, 8'h22);
        tick(); chk_cmd("t2_c0", 32'h1F00, 16'd256);
        tick(); tick(); chk_cmd("t2_c1", 32'h2000, 16'd256);
        tick();
        beats(15);
        chk("t2_no_done_15", {31'd0, bus.desc_done_o}, 32'd0);
        beats(1);
        chk_done("t2", 8'h22);

        // 3: zero-length descriptor completes the cycle after accept with no command
        s0 = strobe_cnt;
        send_desc(32'h3000, 32'd0, 8'h5A);
        chk("t3_noreq", {31'd0, bus.dma_rd_fifo_command_req_o}, 32'd0);
        chk_done("t3", 8'h5A);
        chk("t3_no_strobe", strobe_cnt, s0);

        // 4: back-pressure holds the command stable, then exactly one strobe per command
        bus.dma_rd_fifo_full_i = 1'b1;
        send_desc(32'h4000, 32'd4096, 8'h33);
        tick();
        s0 = strobe_cnt;
        for (int i = 0; i < 10; i++) begin
            chk("t4_full_noreq", {31'd0, bus.dma_rd_fifo_command_req_o}, 32'd0);
            chk("t4_full_addr", bus.dma_rd_addr_o, 32'h4000);
            chk("t4_full_bytes", {16'd0, bus.dma_rd_bytes_to_transfer_o}, 32'd2048);
            tick();
        end
        chk("t4_full_no_strobe", strobe_cnt, s0);
        bus.dma_rd_fifo_full_i = 1'b0;
        #1;
        chk_cmd("t4_c0", 32'h4000, 16'd2048);
        tick(); chk("t4_gap_noreq", {31'd0, bus.dma_rd_fifo_command_req_o}, 32'd0);
        tick(); chk_cmd("t4_c1", 32'h4800, 16'd2048);
        tick();
        chk("t4_two_strobes", strobe_cnt, s0 + 2);
        beats(128);
        chk_done("t4", 8'h33);

        // 5: stray beat in IDLE sets sticky error; counter stays 0 so a 1-beat descriptor still waits
        beats(1);
        chk("t5_err_set", {31'd0, bus.err_o}, 32'd1);
        tick();
        chk("t5_err_sticky", {31'd0, bus.err_o}, 32'd1);
        send_desc(32'h0000_0100, 32'd32, 8'h44);
        tick(); chk_cmd("t5_c0", 32'h100, 16'd32);
        tick();
        chk("t5_wait_no_done", {31'd0, bus.desc_done_o}, 32'd0);
        chk("t5_wait_busy", {31'd0, bus.busy_o}, 32'd1);
        beats(1);
        chk_done("t5", 8'h44);
        chk("t5_err_still", {31'd0, bus.err_o}, 32'd1);

        // 6: async reset in ISSUE while a strobe and a beat coincide
        send_desc(32'h8000, 32'd8192, 8'h66);
        tick();
        chk_cmd("t6_c0", 32'h8000, 16'd2048);
        bus.dma_rd_data_valid_i = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        bus.dma_rd_data_valid_i = 1'b0;
        chk("t6_rst_ready", {31'd0, bus.desc_ready_o}, 32'd1);
        chk("t6_rst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("t6_rst_req", {31'd0, bus.dma_rd_fifo_command_req_o}, 32'd0);
        chk("t6_rst_err", {31'd0, bus.err_o}, 32'd0);
        chk("t6_rst_addr", bus.dma_rd_addr_o, 32'd0);
        chk("t6_rst_bytes", {16'd0, bus.dma_rd_bytes_to_transfer_o}, 32'd0);
        d0 = done_cnt;
        tick();
        @(negedge clk) reset_n = 1'b1;
        tick(); tick(); tick();
        chk("t6_post_ready", {31'd0, bus.desc_ready_o}, 32'd1);
        chk("t6_post_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("t6_no_stray_done", done_cnt, d0);
        beats(1);
        chk("t6_outstanding_zero", {31'd0, bus.err_o}, 32'd1);
        $display("reset test complete, done pulses=%0d strobes=%0d", done_cnt, strobe_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
